// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum collector.
package psum_pkg;

  localparam int unsigned PSUM_WIDTH_DEF = 16;
  localparam int unsigned ROW_MAX_DEF    = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Signed add of two sign-extended operands, clamped to the w-bit signed range.
  // Callers sign-extend to 64 bits and truncate the result back to w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi) return 64'(hi);
    if (s < lo) return 64'(lo);
    return 64'(s);
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Small synchronous FIFO for final results; reads show the head entry combinationally.
module psum_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_wr;
  logic             do_rd;

  // Status flags from wrap-bit pointer comparison; output forced to zero when empty.
  always_comb begin
    empty_o   = (wr_ptr_q == rd_ptr_q);
    full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_wr     = wr_en_i && !full_o;
    do_rd     = rd_en_i && !empty_o;
    rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Read and write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates row partial sums over several passes and streams saturated results out.
module psum_collector
  import psum_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int unsigned ROW_MAX    = ROW_MAX_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [$clog2(ROW_MAX+1)-1:0]        row_len,
  input  logic [7:0]                          num_pass,
  input  logic                                relu_en,
  input  logic                                in_valid,
  input  logic signed [PSUM_WIDTH-1:0]        in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic signed [PSUM_WIDTH-1:0]        out_data,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned LEN_W = $clog2(ROW_MAX + 1);
  localparam int unsigned IDX_W = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;

  state_t                  state_q;
  logic [LEN_W-1:0]        row_len_q;
  logic [7:0]              num_pass_q;
  logic                    relu_q;
  logic [LEN_W-1:0]        elem_cnt_q;
  logic [7:0]              pass_cnt_q;
  logic                    busy_q;
  logic                    done_q;

  logic signed [PSUM_WIDTH-1:0] acc_q [ROW_MAX];
  logic signed [PSUM_WIDTH-1:0] acc_rd;
  logic signed [PSUM_WIDTH-1:0] sum_sat;
  logic signed [PSUM_WIDTH-1:0] result;
  logic signed [PSUM_WIDTH-1:0] push_data;
  logic [IDX_W-1:0]             idx;
  logic                         xfer;
  logic                         first_pass;
  logic                         last_pass;
  logic                         last_elem;
  logic                         push;
  logic                         pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [PSUM_WIDTH-1:0]        fifo_rd;

  // Datapath: read-modify of the current element and handshake decode.
  always_comb begin
    idx        = elem_cnt_q[IDX_W-1:0];
    acc_rd     = acc_q[idx];
    first_pass = (pass_cnt_q == '0);
    last_pass  = (pass_cnt_q == num_pass_q - 8'd1);
    last_elem  = (elem_cnt_q == row_len_q - LEN_W'(1));
    sum_sat    = PSUM_WIDTH'(sat_add(64'(in_data), 64'(acc_rd), PSUM_WIDTH));
    // First pass takes the psum as-is, which also covers single-pass jobs.
    result     = first_pass ? in_data : sum_sat;
    push_data  = (relu_q && result[PSUM_WIDTH-1]) ? '0 : result;
    in_ready   = (state_q == ST_RUN) && !(last_pass && fifo_full);
    xfer       = in_valid && in_ready;
    push       = xfer && last_pass;
    out_valid  = !fifo_empty;
    out_data   = fifo_rd;
    pop        = out_valid && out_ready;
    busy       = busy_q;
    done       = done_q;
  end

  // Accumulation buffer write for all passes but the last.
  always_ff @(posedge clk) begin
    if (xfer && !last_pass) acc_q[idx] <= result;
  end

  // Job control FSM with element/pass counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_len_q  <= '0;
      num_pass_q <= '0;
      relu_q     <= 1'b0;
      elem_cnt_q <= '0;
      pass_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && (row_len != '0) && (num_pass != '0)) begin
            row_len_q  <= row_len;
            num_pass_q <= num_pass;
            relu_q     <= relu_en;
            elem_cnt_q <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (last_elem) begin
              elem_cnt_q <= '0;
              if (last_pass) state_q <= ST_FLUSH;
              else           pass_cnt_q <= pass_cnt_q + 8'd1;
            end else begin
              elem_cnt_q <= elem_cnt_q + LEN_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  psum_fifo #(
    .WIDTH (PSUM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (push_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 The block SHALL have parameter PSUM_WIDTH, default 16: signed width of incoming psums and output results.
REQ-002 The block SHALL have parameter ROW_MAX, default 32: accumulation buffer entries (maximum OFM row length).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of two.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk, input, 1 bit, sole clock, rising edge.
REQ-005 rst, input, 1 bit, asynchronous active-high reset.
REQ-006 start, input, 1 bit, single-cycle job start pulse.
REQ-007 row_len, input, clog2(ROW_MAX+1) bits, psums per pass, latched on start.
REQ-008 num_pass, input, 8 bits, passes to accumulate, latched on start.
REQ-009 relu_en, input, 1 bit, ReLU on final result, latched on start.
REQ-010 in_valid / in_data, input, 1 / PSUM_WIDTH bits, signed psum from the PE column bottom.
REQ-011 in_ready, output, 1 bit, collector can accept in_data.
REQ-012 out_valid / out_data, output, 1 / PSUM_WIDTH bits, signed final OFM value to output buffer.
REQ-013 out_ready, input, 1 bit, downstream accepts out_data.
REQ-014 busy, output, 1 bit, high outside IDLE; done, output, 1 bit, one-cycle pulse on job completion.

Function
REQ-015 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-016 IDLE->RUN on start with row_len!=0 and num_pass!=0; start with either zero is ignored; start outside IDLE is ignored.
REQ-017 Transfer occurs when in_valid && in_ready; elem_cnt counts 0..row_len-1 and wraps to 0, incrementing pass_cnt.
REQ-018 Pass 0: buf[elem_cnt] <= in_data; later passes: buf[elem_cnt] <= sat(buf[elem_cnt] + in_data).
REQ-019 sat: signed add in PSUM_WIDTH+1 bits, clamp to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1].
REQ-020 Last pass (pass_cnt==num_pass-1): result = sat(sum, or in_data if num_pass==1), then zero if relu_en and negative; pushed to FIFO, not written to buf.
REQ-021 in_ready = (state==RUN) && !(last pass && fifo_full); in_ready low in IDLE, FLUSH, DONE.
REQ-022 Result accepted at cycle N SHALL appear at out_data with out_valid at cycle N+1 if FIFO was empty.
REQ-023 out_valid = FIFO non-empty; pop on out_valid && out_ready; simultaneous push and pop when full is not possible (in_ready low); when non-full, both SHALL occur with count unchanged.
REQ-024 RUN->FLUSH on transfer of last element of last pass; FLUSH->DONE when FIFO empty; DONE->IDLE next cycle with done=1 for that one cycle.
REQ-025 Output order SHALL equal element order; no result dropped or duplicated.

Reset
REQ-026 On rst: state=IDLE, elem_cnt=0, pass_cnt=0, FIFO empty, in_ready=0, out_valid=0, out_data=0, busy=0, done=0; buf contents not reset.
REQ-027 Reset asserted mid-job SHALL abort the job; no out_valid until a new job's last pass.

Structure
REQ-028 Shared package psum_pkg SHALL hold the FSM state type, default widths, and the saturating-add function.
REQ-029 Output queue SHALL be a separate sub-module psum_fifo (parameterised width/depth, registered storage, full/empty flags).
REQ-030 buf SHALL be a ROW_MAX x PSUM_WIDTH register array, one read and one write port.

Verification
REQ-031 row_len=4, num_pass=1, inputs 1,2,3,4, out_ready=1 -> outputs 1,2,3,4 in order, then done pulse, busy low.
REQ-032 row_len=2, num_pass=3, inputs 10,-3 each pass -> outputs 30,-9.
REQ-033 num_pass=2, inputs 20000 then 20000 -> 32767; -20000 then -20000 -> -32768.
REQ-034 relu_en=1, num_pass=1, inputs -5,7 -> outputs 0,7.
REQ-035 row_len=6, num_pass=1, out_ready=0 -> in_ready drops after 4th transfer; raising out_ready resumes; all 6 outputs delivered in order.
REQ-036 rst mid-pass 2 of 3 -> all outputs at reset values, busy=0; new job with num_pass=1 inputs 5 -> output 5.
